// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM states, wait-counter width, byte-lane map.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int WAIT_W = 4;
  localparam int LANES  = 4;

  // Big-endian lanes: byte offset 0 sits in bits [31:24].
  function automatic int lane_lsb(input int lane);
    return 8 * (LANES - 1 - lane);
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with one 4-byte port; lane addresses wrap modulo the array depth.
// Read is combinational, write lands on the rising edge while we=1; contents are never reset.
module mem_byte_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] base,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // ADDR_W-bit addition gives the mod-depth wrap for free.
    assign idx[i] = base + ADDR_W'(i);
    assign rdata[lane_lsb(i) +: 8] = mem[idx[i]];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        mem[idx[i]] <= wdata[lane_lsb(i) +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one access at a time, WAIT wait states, single-cycle ready strobe.
// Optional alignment checking is enabled by defining MEM_RESP_ALIGN_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              wr_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] arr_base;
  logic [31:0]       arr_rdata;
  logic              arr_we;
  logic              misaligned;
  logic              cur_wr, cur_err;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // With WAIT=0 RESP is entered on the sampling edge, so the array must see the live address in IDLE.
  assign arr_base = (state == S_IDLE) ? addr[ADDR_W-1:0] : addr_q;
  assign cur_wr   = (state == S_IDLE) ? wr : wr_q;
  assign cur_err  = (state == S_IDLE) ? misaligned : err_q;

  assign ready  = (state == S_RESP);
  assign err    = ready & err_q;
  assign arr_we = ready & wr_q & ~err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_nxt   = WAIT_W'(WAIT);
          state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= WAIT_W'(1)) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        wr_q    <= wr;
        err_q   <= misaligned;
        addr_q  <= addr[ADDR_W-1:0];
        wdata_q <= wdata;
      end
      if (state_nxt == S_RESP && state != S_RESP) begin
        if (cur_err)     rdata <= '0;
        else if (!cur_wr) rdata <= arr_rdata;
      end
    end
  end

  mem_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .base (arr_base),
    .we   (arr_we),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses WAIT=2, instance 1 uses WAIT=0; both checked against a byte-array model.
module tb_mem_responder;

  localparam int NI = 2;

  logic        clk;
  logic        reset;
  logic        req_s   [NI];
  logic        wr_s    [NI];
  logic [31:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic [31:0] rdata_s [NI];
  logic        ready_s [NI];
  logic        err_s   [NI];

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl  [NI][256];
  logic [31:0] last [NI];

  mem_responder #(.ADDR_W(8), .WAIT(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0])
  );

  mem_responder #(.ADDR_W(8), .WAIT(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] mdl_word(input int u, input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = mdl[u][(a + i) % 256];
    return w;
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Caller must be at a negedge with the instance idle; returns at a negedge one cycle after the response.
  task automatic txn(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    exp_err = is_misaligned(a);
    if (exp_err) begin
      exp_rd = 32'h0;
    end else if (w) begin
      for (int i = 0; i < 4; i++) mdl[u][(a + i) % 256] = d[31-8*i -: 8];
      exp_rd = last[u];
    end else begin
      exp_rd = mdl_word(u, a);
    end
    last[u] = exp_rd;

    req_s[u] = 1'b1; wr_s[u] = w; addr_s[u] = a; wdata_s[u] = d;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!ready_s[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    req_s[u] = 1'b0; wr_s[u] = 1'($urandom); addr_s[u] = $urandom; wdata_s[u] = $urandom;
    got = rdata_s[u];
    chk("latency", lat, wait_of(u));
    chk("err", err_s[u], exp_err);
    chk("rdata", rdata_s[u], exp_rd);
    @(negedge clk);
    chk("ready_pulse", ready_s[u], 0);
  endtask

  initial begin
    logic [31:0] g;
    logic [31:0] hold_exp;
    int          pulses;

    reset = 1'b0;
    for (int u = 0; u < NI; u++) begin
      req_s[u] = 0; wr_s[u] = 0; addr_s[u] = 0; wdata_s[u] = 0; last[u] = 0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < NI; u++) begin
      chk("rst_ready", ready_s[u], 0);
      chk("rst_err", err_s[u], 0);
      chk("rst_rdata", rdata_s[u], 0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Fill both arrays so every later read has defined contents.
    for (int u = 0; u < NI; u++)
      for (int k = 0; k < 64; k++) txn(u, 1'b1, 32'(k * 4), $urandom, g);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, g);
    txn(0, 1'b0, 32'h10, 32'h0, g);
    chk("deadbeef", g, 32'hDEADBEEF);
    chk("byte10", {24'h0, g[31:24]}, 32'hDE);

    txn(1, 1'b1, 32'h00, 32'h01234567, g);
    txn(1, 1'b1, 32'h04, 32'h89ABCDEF, g);
    txn(1, 1'b0, 32'h00, 32'h0, g);
    chk("b2b_rd0", g, 32'h01234567);
    txn(1, 1'b0, 32'h04, 32'h0, g);
    chk("b2b_rd4", g, 32'h89ABCDEF);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    txn(0, 1'b1, 32'h13, 32'h5A5A5A5A, g);
    txn(0, 1'b0, 32'h10, 32'h0, g);
    chk("align_keep", g, 32'hDEADBEEF);
`else
    txn(0, 1'b1, 32'hFE, 32'h11223344, g);
    txn(0, 1'b0, 32'hFC, 32'h0, g);
    chk("wrap_fc", {16'h0, g[15:0]}, 32'h1122);
    txn(0, 1'b0, 32'h00, 32'h0, g);
    chk("wrap_00", {16'h0, g[31:16]}, 32'h3344);
    txn(0, 1'b0, 32'hFE, 32'h0, g);
    chk("wrap_fe", g, 32'h11223344);
`endif

    txn(0, 1'b1, 32'h0000_0120, 32'hCAFEF00D, g);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, g);
    chk("alias", g, 32'hCAFEF00D);

    // Reset during the wait states of a write: the write must be dropped.
    txn(0, 1'b1, 32'h20, 32'hAAAAAAAA, g);
    req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_s[0] = 1'b0;
    #1;
    chk("abort_ready", ready_s[0], 0);
    chk("abort_rdata", rdata_s[0], 0);
    @(negedge clk);
    reset = 1'b1;
    last[0] = 0; last[1] = 0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(ready_s[0]);
    end
    chk("abort_no_ready", pulses, 0);
    txn(0, 1'b0, 32'h20, 32'h0, g);
    chk("abort_keep", g, 32'hAAAAAAAA);

    // req held high on the WAIT=0 instance: one response every two cycles.
    hold_exp = mdl_word(1, 32'h40);
    req_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_ready", ready_s[1], 32'((k % 2) == 0));
      if ((k % 2) == 0) chk("hold_rdata", rdata_s[1], hold_exp);
    end
    req_s[1] = 1'b0;
    last[1] = hold_exp;

    for (int u = 0; u < NI; u++) begin
      for (int k = 0; k < 40; k++) begin
        logic [31:0] ra;
        ra = $urandom;
        if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
        txn(u, 1'($urandom_range(0, 1)), ra, $urandom, g);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
